mem_arbiter: RTL and testbench

- Shares one single-ported unified memory between the instruction-fetch requester (IF) and the data-access requester (D, load/store).
- Sits between the fetch stage / data-memory stage and the backing memory.
- Allows one outstanding memory transaction at a time, using request/grant/response handshakes.
- D normally has priority; a starvation guard guarantees IF forward progress.

---
 rtl/mem_arb_pkg.sv | 29 ++
 rtl/mem_arb_sel.sv | 52 +++++
 rtl/mem_arbiter.sv | 194 +++++++++++++++++++
 tb/tb_mem_arbiter.sv | 327 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types for the unified-memory arbiter: FSM states, request sources
// and the registered memory-request bundle.
package mem_arb_pkg;

  // Field widths of the registered memory request; the arbiter's ADDR_W and
  // DATA_W parameters default to these and are expected to match them.
  localparam int unsigned ARB_ADDR_W = 32;
  localparam int unsigned ARB_DATA_W = 32;
  localparam int unsigned ARB_STRB_W = ARB_DATA_W / 8;

  typedef enum logic [1:0] {
    IDLE,
    BUSY_I,
    BUSY_D
  } state_t;

  typedef enum logic {
    SRC_IF,
    SRC_D
  } src_t;

  typedef struct packed {
    logic                  we;
    logic [ARB_ADDR_W-1:0] addr;
    logic [ARB_DATA_W-1:0] wdata;
    logic [ARB_STRB_W-1:0] wstrb;
  } mem_req_t;

endpackage

// File: rtl/mem_arb_sel.sv
// Arbitration select for mem_arbiter: data side wins by default, fetch wins
// once it has been pending for MAX_WAIT cycles without a grant.
import mem_arb_pkg::*;

module mem_arb_sel #(
  parameter int unsigned MAX_WAIT = 4,
  localparam int unsigned CntW = $clog2(MAX_WAIT + 1)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            if_req,
  input  logic            d_req,
  input  logic            idle,
  input  logic            if_taken,
  output src_t            winner,
  output logic [CntW-1:0] wait_cnt
);

  localparam logic [CntW-1:0] MaxCnt = CntW'(MAX_WAIT);

  logic [CntW-1:0] wait_q, wait_d;

  // Starvation counter register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wait_q <= '0;
    end else begin
      wait_q <= wait_d;
    end
  end

  // Count every cycle IF is pending but not granted (busy cycles included).
  always_comb begin
    wait_d = wait_q;
    if (if_taken) begin
      wait_d = '0;
    end else if (if_req && (wait_q != MaxCnt)) begin
      wait_d = wait_q + CntW'(1);
    end
  end

  // Winner: IF when it is alone or starved, otherwise D.
  always_comb begin
    winner = SRC_D;
    if (idle && if_req && (!d_req || (wait_q == MaxCnt))) begin
      winner = SRC_IF;
    end
  end

  assign wait_cnt = wait_q;

endmodule

// File: rtl/mem_arbiter.sv
// Single-outstanding arbiter sharing one memory port between instruction
// fetch (IF) and data access (D). Optional watchdog abort is enabled by
// defining MEM_ARB_TIMEOUT_EN.
import mem_arb_pkg::*;

module mem_arbiter #(
  parameter int unsigned ADDR_W   = ARB_ADDR_W,
  parameter int unsigned DATA_W   = ARB_DATA_W,
  parameter int unsigned MAX_WAIT = 4
`ifdef MEM_ARB_TIMEOUT_EN
  ,
  parameter int unsigned TIMEOUT  = 64
`endif
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                if_req,
  input  logic [ADDR_W-1:0]   if_addr,
  output logic                if_gnt,
  output logic                if_rvalid,
  output logic [DATA_W-1:0]   if_rdata,
  output logic                if_err,
  input  logic                d_req,
  input  logic                d_we,
  input  logic [ADDR_W-1:0]   d_addr,
  input  logic [DATA_W-1:0]   d_wdata,
  input  logic [DATA_W/8-1:0] d_wstrb,
  output logic                d_gnt,
  output logic                d_rvalid,
  output logic [DATA_W-1:0]   d_rdata,
  output logic                d_err,
  output logic                m_req,
  output logic                m_we,
  output logic [ADDR_W-1:0]   m_addr,
  output logic [DATA_W-1:0]   m_wdata,
  output logic [DATA_W/8-1:0] m_wstrb,
  input  logic                m_ack,
  input  logic [DATA_W-1:0]   m_rdata
);

  localparam int unsigned CntW = $clog2(MAX_WAIT + 1);

  state_t          state_q, state_d;
  mem_req_t        mreq_q, mreq_d;
  logic            if_rvalid_q, if_rvalid_d;
  logic            d_rvalid_q, d_rvalid_d;
  logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
  logic [DATA_W-1:0] d_rdata_q, d_rdata_d;

  logic            idle, busy, done, abort, fin;
  src_t            winner;
  logic [CntW-1:0] wait_cnt;

  assign idle = (state_q == IDLE);
  assign busy = !idle;
  assign done = busy && m_ack;
  assign fin  = done || abort;

  mem_arb_sel #(
    .MAX_WAIT (MAX_WAIT)
  ) u_sel (
    .clk      (clk),
    .reset    (reset),
    .if_req   (if_req),
    .d_req    (d_req),
    .idle     (idle),
    .if_taken (if_gnt),
    .winner   (winner),
    .wait_cnt (wait_cnt)
  );

  // Grants are combinational and suppressed while reset is held.
  assign if_gnt = !reset && idle && if_req && (winner == SRC_IF);
  assign d_gnt  = !reset && idle && d_req && (winner == SRC_D);

`ifdef MEM_ARB_TIMEOUT_EN
  localparam int unsigned WdW = $clog2(TIMEOUT);

  logic [WdW-1:0] wd_q;
  logic           if_err_q, d_err_q;

  assign abort = busy && !m_ack && (wd_q == WdW'(TIMEOUT - 1));

  // Watchdog: counts busy cycles without m_ack, restarts on every new grant.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wd_q <= '0;
    end else if (!busy || fin) begin
      wd_q <= '0;
    end else begin
      wd_q <= wd_q + WdW'(1);
    end
  end

  // Error flags accompany the rvalid of an aborted transaction.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      if_err_q <= 1'b0;
      d_err_q  <= 1'b0;
    end else begin
      if_err_q <= abort && (state_q == BUSY_I);
      d_err_q  <= abort && (state_q == BUSY_D);
    end
  end

  assign if_err = if_err_q;
  assign d_err  = d_err_q;
`else
  assign abort  = 1'b0;
  assign if_err = 1'b0;
  assign d_err  = 1'b0;
`endif

  // State, request and response registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      mreq_q      <= '0;
      if_rvalid_q <= 1'b0;
      d_rvalid_q  <= 1'b0;
      if_rdata_q  <= '0;
      d_rdata_q   <= '0;
    end else begin
      state_q     <= state_d;
      mreq_q      <= mreq_d;
      if_rvalid_q <= if_rvalid_d;
      d_rvalid_q  <= d_rvalid_d;
      if_rdata_q  <= if_rdata_d;
      d_rdata_q   <= d_rdata_d;
    end
  end

  // Next state: latch the granted request, retire on m_ack or abort.
  always_comb begin
    state_d     = state_q;
    mreq_d      = mreq_q;
    if_rvalid_d = 1'b0;
    d_rvalid_d  = 1'b0;
    if_rdata_d  = if_rdata_q;
    d_rdata_d   = d_rdata_q;
    case (state_q)
      IDLE: begin
        if (if_gnt) begin
          state_d      = BUSY_I;
          mreq_d.we    = 1'b0;
          mreq_d.addr  = if_addr;
          mreq_d.wdata = '0;
          mreq_d.wstrb = '0;
        end else if (d_gnt) begin
          state_d      = BUSY_D;
          mreq_d.we    = d_we;
          mreq_d.addr  = d_addr;
          mreq_d.wdata = d_wdata;
          mreq_d.wstrb = d_wstrb;
        end
      end
      BUSY_I: begin
        if (fin) begin
          state_d     = IDLE;
          if_rvalid_d = 1'b1;
          if_rdata_d  = abort ? '0 : m_rdata;
        end
      end
      BUSY_D: begin
        if (fin) begin
          state_d    = IDLE;
          d_rvalid_d = 1'b1;
          // Stores return zero data.
          d_rdata_d  = (abort || mreq_q.we) ? '0 : m_rdata;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign m_req     = busy;
  assign m_we      = mreq_q.we;
  assign m_addr    = mreq_q.addr;
  assign m_wdata   = mreq_q.wdata;
  assign m_wstrb   = mreq_q.wstrb;
  assign if_rvalid = if_rvalid_q;
  assign d_rvalid  = d_rvalid_q;
  assign if_rdata  = if_rdata_q;
  assign d_rdata   = d_rdata_q;

  // Sanity: never two grants at once, counter never passes its ceiling.
  always @(posedge clk) begin
    if (!reset) begin
      assert (!(if_gnt && d_gnt));
      assert (wait_cnt <= CntW'(MAX_WAIT));
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter. Inputs are driven just after
// the falling edge; outputs are sampled 1 time unit later.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        if_req = 1'b0;
  logic [31:0] if_addr = '0;
  logic        if_gnt, if_rvalid, if_err;
  logic [31:0] if_rdata;
  logic        d_req = 1'b0;
  logic        d_we = 1'b0;
  logic [31:0] d_addr = '0;
  logic [31:0] d_wdata = '0;
  logic [3:0]  d_wstrb = '0;
  logic        d_gnt, d_rvalid, d_err;
  logic [31:0] d_rdata;
  logic        m_req, m_we;
  logic [31:0] m_addr, m_wdata;
  logic [3:0]  m_wstrb;
  logic        m_ack = 1'b0;
  logic [31:0] m_rdata = '0;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  mem_arbiter dut (
    .clk       (clk),
    .reset     (reset),
    .if_req    (if_req),
    .if_addr   (if_addr),
    .if_gnt    (if_gnt),
    .if_rvalid (if_rvalid),
    .if_rdata  (if_rdata),
    .if_err    (if_err),
    .d_req     (d_req),
    .d_we      (d_we),
    .d_addr    (d_addr),
    .d_wdata   (d_wdata),
    .d_wstrb   (d_wstrb),
    .d_gnt     (d_gnt),
    .d_rvalid  (d_rvalid),
    .d_rdata   (d_rdata),
    .d_err     (d_err),
    .m_req     (m_req),
    .m_we      (m_we),
    .m_addr    (m_addr),
    .m_wdata   (m_wdata),
    .m_wstrb   (m_wstrb),
    .m_ack     (m_ack),
    .m_rdata   (m_rdata)
  );

  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic test_reset();
    cyc(); if_req = 1'b1; d_req = 1'b1; #1;
    checks++;
    if ({if_gnt, d_gnt, m_req, if_rvalid, d_rvalid, if_err, d_err} !== 7'b0) begin
      errors++;
      $display("FAIL reset_ctrl: got %b want 0000000",
               {if_gnt, d_gnt, m_req, if_rvalid, d_rvalid, if_err, d_err});
    end
    checks++;
    if ({if_rdata, d_rdata, m_addr, m_wdata} !== 128'h0) begin
      errors++;
      $display("FAIL reset_data: got %h %h %h %h want 0", if_rdata, d_rdata, m_addr, m_wdata);
    end
    cyc(); reset = 1'b0; if_req = 1'b0; d_req = 1'b0; #1;
    checks++;
    if (m_req !== 1'b0) begin
      errors++; $display("FAIL reset_release_mreq: got %b want 0", m_req);
    end
  endtask

  task automatic test_lone_fetch();
    cyc(); if_req = 1'b1; if_addr = 32'h100; #1;
    checks++;
    if ({if_gnt, d_gnt, m_req} !== 3'b100) begin
      errors++; $display("FAIL fetch_c0: got %b want 100", {if_gnt, d_gnt, m_req});
    end
    cyc(); if_req = 1'b0; m_ack = 1'b1; m_rdata = 32'h0050_0093; #1;
    checks++;
    if ({m_req, m_we, m_wstrb, m_addr, if_gnt, if_rvalid} !== {2'b10, 4'h0, 32'h100, 2'b00}) begin
      errors++;
      $display("FAIL fetch_c1: got req=%b we=%b strb=%h addr=%h gnt=%b rv=%b want 1 0 0 100 0 0",
               m_req, m_we, m_wstrb, m_addr, if_gnt, if_rvalid);
    end
    cyc(); m_ack = 1'b0; m_rdata = '0; #1;
    checks++;
    if ({if_rvalid, if_err, m_req, if_rdata} !== {3'b100, 32'h0050_0093}) begin
      errors++;
      $display("FAIL fetch_c2: got rv=%b err=%b req=%b data=%h want 1 0 0 00500093",
               if_rvalid, if_err, m_req, if_rdata);
    end
    // Stray ack while idle must be ignored.
    cyc(); m_ack = 1'b1; m_rdata = 32'hFFFF_FFFF; #1;
    checks++;
    if ({if_rvalid, m_req, if_rdata} !== {2'b00, 32'h0050_0093}) begin
      errors++;
      $display("FAIL fetch_hold: got rv=%b req=%b data=%h want 0 0 00500093",
               if_rvalid, m_req, if_rdata);
    end
    cyc(); m_ack = 1'b0; #1;
    checks++;
    if ({if_rvalid, d_rvalid, m_req} !== 3'b000) begin
      errors++;
      $display("FAIL idle_ack_ignored: got %b want 000", {if_rvalid, d_rvalid, m_req});
    end
  endtask

  task automatic test_simultaneous();
    cyc();
    if_req = 1'b1; if_addr = 32'h104;
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h200; d_wdata = 32'hDEAD_BEEF; d_wstrb = 4'hF; #1;
    checks++;
    if ({d_gnt, if_gnt} !== 2'b10) begin
      errors++; $display("FAIL sim_gnt: got d=%b if=%b want 1 0", d_gnt, if_gnt);
    end
    cyc(); d_req = 1'b0; m_ack = 1'b1; m_rdata = 32'h1234_5678; #1;
    checks++;
    if ({m_req, m_we, m_wstrb, m_addr, m_wdata, if_gnt} !==
        {2'b11, 4'hF, 32'h200, 32'hDEAD_BEEF, 1'b0}) begin
      errors++;
      $display("FAIL sim_store: got req=%b we=%b strb=%h addr=%h wdata=%h ignt=%b",
               m_req, m_we, m_wstrb, m_addr, m_wdata, if_gnt);
    end
    cyc(); m_ack = 1'b0; #1;
    checks++;
    if ({d_rvalid, d_err, if_gnt, d_rdata} !== {3'b101, 32'h0}) begin
      errors++;
      $display("FAIL sim_store_done: got rv=%b err=%b ignt=%b rdata=%h want 1 0 1 0",
               d_rvalid, d_err, if_gnt, d_rdata);
    end
    cyc(); if_req = 1'b0; m_ack = 1'b1; m_rdata = 32'hCAFE_F00D; #1;
    checks++;
    if ({m_we, m_wstrb, m_addr, d_rvalid} !== {1'b0, 4'h0, 32'h104, 1'b0}) begin
      errors++;
      $display("FAIL sim_fetch_req: got we=%b strb=%h addr=%h drv=%b want 0 0 104 0",
               m_we, m_wstrb, m_addr, d_rvalid);
    end
    cyc(); m_ack = 1'b0; #1;
    checks++;
    if ({if_rvalid, if_rdata} !== {1'b1, 32'hCAFE_F00D}) begin
      errors++; $display("FAIL sim_fetch_done: got rv=%b data=%h want 1 cafef00d",
                         if_rvalid, if_rdata);
    end
  endtask

  task automatic test_starvation();
    cyc(); if_req = 1'b1; if_addr = 32'h108;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h300; #1;
    checks++;
    if ({d_gnt, if_gnt} !== 2'b10) begin
      errors++; $display("FAIL starve_c0: got d=%b if=%b want 1 0", d_gnt, if_gnt);
    end
    cyc(); m_ack = 1'b1; m_rdata = 32'h1; #1;
    checks++;
    if ({d_gnt, if_gnt} !== 2'b00) begin
      errors++; $display("FAIL starve_busy_nogrant: got d=%b if=%b want 0 0", d_gnt, if_gnt);
    end
    cyc(); m_ack = 1'b0; #1;
    checks++;
    if ({d_gnt, if_gnt, d_rvalid} !== 3'b101) begin
      errors++; $display("FAIL starve_c2: got %b want 101", {d_gnt, if_gnt, d_rvalid});
    end
    cyc(); m_ack = 1'b1; m_rdata = 32'h2; #1;
    cyc(); m_ack = 1'b0; #1;
    checks++;
    if ({if_gnt, d_gnt, d_rvalid, d_rdata} !== {3'b101, 32'h2}) begin
      errors++;
      $display("FAIL starve_if_wins: got ignt=%b dgnt=%b drv=%b rdata=%h want 1 0 1 2",
               if_gnt, d_gnt, d_rvalid, d_rdata);
    end
    cyc(); m_ack = 1'b1; m_rdata = 32'h3; #1;
    checks++;
    if (m_addr !== 32'h108) begin
      errors++; $display("FAIL starve_if_addr: got %h want 108", m_addr);
    end
    // Counter was cleared by the IF grant, so D wins again.
    cyc(); m_ack = 1'b0; #1;
    checks++;
    if ({if_rvalid, d_gnt, if_gnt, if_rdata} !== {3'b110, 32'h3}) begin
      errors++;
      $display("FAIL starve_cleared: got irv=%b dgnt=%b ignt=%b data=%h want 1 1 0 3",
               if_rvalid, d_gnt, if_gnt, if_rdata);
    end
    // IF withdraws before being granted: it is not served.
    cyc(); if_req = 1'b0; d_req = 1'b0; m_ack = 1'b1; m_rdata = 32'h4; #1;
    cyc(); m_ack = 1'b0; #1;
    checks++;
    if ({d_rvalid, if_gnt, d_rdata} !== {2'b10, 32'h4}) begin
      errors++; $display("FAIL starve_drop: got drv=%b ignt=%b data=%h want 1 0 4",
                         d_rvalid, if_gnt, d_rdata);
    end
    cyc(); #1;
    checks++;
    if ({m_req, if_rvalid, d_rvalid} !== 3'b000) begin
      errors++; $display("FAIL starve_quiet: got %b want 000", {m_req, if_rvalid, d_rvalid});
    end
  endtask

  task automatic test_reset_mid();
    cyc(); d_req = 1'b1; d_we = 1'b0; d_addr = 32'h400; #1;
    checks++;
    if (d_gnt !== 1'b1) begin
      errors++; $display("FAIL rmid_gnt: got %b want 1", d_gnt);
    end
    cyc(); d_req = 1'b0; #1;
    checks++;
    if (m_req !== 1'b1) begin
      errors++; $display("FAIL rmid_busy: got %b want 1", m_req);
    end
    cyc(); reset = 1'b1; #1;
    checks++;
    if ({m_req, d_gnt} !== 2'b00) begin
      errors++; $display("FAIL rmid_drop: got %b want 00", {m_req, d_gnt});
    end
    cyc(); reset = 1'b0; #1;
    cyc(); m_ack = 1'b1; m_rdata = 32'hBAD; #1;
    cyc(); m_ack = 1'b0; if_req = 1'b1; if_addr = 32'h10C; #1;
    checks++;
    if ({d_rvalid, m_req, if_gnt, d_rdata} !== {3'b001, 32'h0}) begin
      errors++;
      $display("FAIL rmid_idle: got drv=%b mreq=%b ignt=%b drdata=%h want 0 0 1 0",
               d_rvalid, m_req, if_gnt, d_rdata);
    end
    cyc(); if_req = 1'b0; m_ack = 1'b1; m_rdata = 32'h777; #1;
    cyc(); m_ack = 1'b0; #1;
    checks++;
    if ({if_rvalid, if_rdata} !== {1'b1, 32'h777}) begin
      errors++; $display("FAIL rmid_after: got rv=%b data=%h want 1 777", if_rvalid, if_rdata);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] addrs [3] = '{32'h500, 32'h504, 32'h508};
    logic [31:0] datas [3] = '{32'h1111_1111, 32'h2222_2222, 32'h3333_3333};
    int          lats  [3] = '{0, 3, 7};
    for (int i = 0; i < 3; i++) begin
      cyc(); d_req = 1'b1; d_we = 1'b0; d_addr = addrs[i]; m_ack = 1'b0; #1;
      checks++;
      if (d_gnt !== 1'b1) begin
        errors++; $display("FAIL b2b_gnt%0d: got %b want 1", i, d_gnt);
      end
      if (i > 0) begin
        checks++;
        if ({d_rvalid, d_rdata} !== {1'b1, datas[i-1]}) begin
          errors++; $display("FAIL b2b_data%0d: got rv=%b data=%h want 1 %h",
                             i - 1, d_rvalid, d_rdata, datas[i-1]);
        end
      end
      for (int j = 0; j < lats[i]; j++) begin
        cyc(); d_req = 1'b0; m_ack = 1'b0; #1;
        checks++;
        if ({m_req, d_rvalid, d_gnt, m_addr} !== {3'b100, addrs[i]}) begin
          errors++; $display("FAIL b2b_wait%0d_%0d: got req=%b rv=%b gnt=%b addr=%h",
                             i, j, m_req, d_rvalid, d_gnt, m_addr);
        end
      end
      cyc(); d_req = 1'b0; m_ack = 1'b1; m_rdata = datas[i]; #1;
      checks++;
      if ({m_req, d_rvalid, m_addr} !== {2'b10, addrs[i]}) begin
        errors++; $display("FAIL b2b_ack%0d: got req=%b rv=%b addr=%h", i, m_req, d_rvalid, m_addr);
      end
    end
    cyc(); m_ack = 1'b0; m_rdata = '0; #1;
    checks++;
    if ({d_rvalid, d_rdata} !== {1'b1, datas[2]}) begin
      errors++; $display("FAIL b2b_data2: got rv=%b data=%h want 1 %h", d_rvalid, d_rdata, datas[2]);
    end
    cyc(); #1;
    checks++;
    if ({d_rvalid, m_req, d_rdata} !== {2'b00, datas[2]}) begin
      errors++; $display("FAIL b2b_nodup: got rv=%b req=%b data=%h", d_rvalid, m_req, d_rdata);
    end
  endtask

`ifdef MEM_ARB_TIMEOUT_EN
  task automatic test_timeout();
    cyc(); d_req = 1'b1; d_we = 1'b0; d_addr = 32'h600; #1;
    checks++;
    if (d_gnt !== 1'b1) begin
      errors++; $display("FAIL to_gnt: got %b want 1", d_gnt);
    end
    for (int k = 1; k <= 64; k++) begin
      cyc(); d_req = 1'b0; #1;
      checks++;
      if ({m_req, d_rvalid} !== 2'b10) begin
        errors++; $display("FAIL to_wait%0d: got req=%b rv=%b want 1 0", k, m_req, d_rvalid);
      end
    end
    cyc(); #1;
    checks++;
    if ({m_req, d_rvalid, d_err, d_rdata} !== {3'b011, 32'h0}) begin
      errors++; $display("FAIL to_abort: got req=%b rv=%b err=%b data=%h want 0 1 1 0",
                         m_req, d_rvalid, d_err, d_rdata);
    end
    cyc(); m_ack = 1'b1; m_rdata = 32'h5; #1;
    cyc(); m_ack = 1'b0; #1;
    checks++;
    if ({m_req, d_rvalid, d_err, d_rdata} !== {3'b000, 32'h0}) begin
      errors++; $display("FAIL to_late_ack: got req=%b rv=%b err=%b data=%h want 0 0 0 0",
                         m_req, d_rvalid, d_err, d_rdata);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_lone_fetch();
    test_simultaneous();
    test_starvation();
    test_reset_mid();
    test_back_to_back();
`ifdef MEM_ARB_TIMEOUT_EN
    test_timeout();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
